// File: rtl/addr8s_redundant_sched.sv
// addr8s_redundant_sched: round-robin temporal-redundancy controller for a shared 8-bit signed adder.
// Each operation runs twice with swapped operands, retries on mismatch, and reports a persistent error.
module addr8s_redundant_sched #(
    parameter int unsigned MAX_RETRY = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [7:0] req0_a,
    input  logic [7:0] req0_b,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [7:0] req1_a,
    input  logic [7:0] req1_b,
    output logic [7:0] add_a,
    output logic [7:0] add_b,
    input  logic [8:0] add_o,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [8:0] rsp_sum,
    output logic       rsp_id,
    output logic       rsp_err,
    output logic [7:0] mismatch_cnt
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RUN1  = 3'd1;
    localparam logic [2:0] S_RUN2  = 3'd2;
    localparam logic [2:0] S_CHECK = 3'd3;
    localparam logic [2:0] S_RESP  = 3'd4;
    localparam logic [2:0] MR      = 3'(MAX_RETRY);

    logic [2:0] r_state;
    logic       r_ptr;
    logic [7:0] r_a;
    logic [7:0] r_b;
    logic       r_id;
    logic [2:0] r_retry;
    logic [8:0] r_r1;
    logic [8:0] r_r2;
    logic       r_err;
    logic [7:0] r_mcnt;
    logic       w_g0;
    logic       w_g1;
    logic       w_hs;
    logic       w_mis;

    // r_ptr holds the last granted requester; on a tie the other one wins
    always_comb begin
        w_g0         = req0_valid & (~req1_valid | r_ptr);
        w_g1         = req1_valid & (~req0_valid | ~r_ptr);
        req0_ready   = (r_state == S_IDLE) & w_g0;
        req1_ready   = (r_state == S_IDLE) & w_g1;
        w_hs         = req0_ready | req1_ready;
        add_a        = (r_state == S_RUN1) ? r_a : (r_state == S_RUN2) ? r_b : 8'd0;
        add_b        = (r_state == S_RUN1) ? r_b : (r_state == S_RUN2) ? r_a : 8'd0;
        w_mis        = r_r1 != r_r2;
        rsp_valid    = r_state == S_RESP;
        rsp_sum      = r_r1;
        rsp_id       = r_id;
        rsp_err      = r_err;
        mismatch_cnt = r_mcnt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_ptr   <= 1'b1;
            r_a     <= 8'd0;
            r_b     <= 8'd0;
            r_id    <= 1'b0;
            r_retry <= 3'd0;
            r_r1    <= 9'd0;
            r_r2    <= 9'd0;
            r_err   <= 1'b0;
            r_mcnt  <= 8'd0;
        end else begin
            case (r_state)
                S_IDLE: if (w_hs) begin
                    r_a     <= w_g0 ? req0_a : req1_a;
                    r_b     <= w_g0 ? req0_b : req1_b;
                    r_id    <= w_g1;
                    r_ptr   <= w_g1;
                    r_retry <= 3'd0;
                    r_state <= S_RUN1;
                end
                S_RUN1: begin
                    r_r1    <= add_o;
                    r_state <= S_RUN2;
                end
                S_RUN2: begin
                    r_r2    <= add_o;
                    r_state <= S_CHECK;
                end
                S_CHECK: if (!w_mis) begin
                    r_err   <= 1'b0;
                    r_state <= S_RESP;
                end else begin
                    if (r_mcnt != 8'hFF) r_mcnt <= r_mcnt + 8'd1;
                    if (r_retry < MR) begin
                        r_retry <= r_retry + 3'd1;
                        r_state <= S_RUN1;
                    end else begin
                        r_err   <= 1'b1;
                        r_state <= S_RESP;
                    end
                end
                S_RESP: if (rsp_ready) r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_addr8s_redundant_sched.sv
// tb_addr8s_redundant_sched: directed and randomized checks against a cycle-level behavioural model.
module tb_addr8s_redundant_sched;
    localparam int MR = 2;

    logic       clk = 0;
    logic       rst = 1;
    logic       req0_valid = 0, req1_valid = 0, req0_ready, req1_ready;
    logic [7:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0, add_a, add_b;
    logic [8:0] add_o, rsp_sum;
    logic       rsp_valid, rsp_ready, rsp_id, rsp_err;
    logic [7:0] mismatch_cnt;
    logic       rand_mode = 0, rdy_fixed = 1, rnd_rdy = 0, m_corrupt = 0;
    int         errors = 0, checks = 0, cyc = 0;

    bit         m_on = 0, m_busy = 0, m_ptr = 1, m_id = 0, m_err = 0, last_id = 0, obs_seen = 0;
    int         m_k = 0, m_done = 0, m_c = 0, corr_c = 0, m_mcnt = 0;
    logic [7:0] m_a = 0, m_b = 0;
    logic [8:0] m_sum = 0;
    int         acc_t[$];
    bit         acc_id[$];
    int         obs_lat = 0, obs_sum = 0, obs_id = 0, obs_err = 0, obs_mcnt = 0;

    addr8s_redundant_sched #(.MAX_RETRY(MR)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .add_a(add_a), .add_b(add_b), .add_o(add_o),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_sum(rsp_sum), .rsp_id(rsp_id),
        .rsp_err(rsp_err), .mismatch_cnt(mismatch_cnt)
    );

    // External adder with optional bit-3 fault injection during the swapped pass
    assign add_o = ({add_a[7], add_a} + {add_b[7], add_b}) ^ (m_corrupt ? 9'h008 : 9'h000);
    assign rsp_ready = rand_mode ? rnd_rdy : rdy_fixed;

    initial forever #5 clk = ~clk;
    always @(posedge clk) begin
        #1;
        rnd_rdy = ($urandom_range(0, 1) == 1);
    end

    function automatic void chk(input string n, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", n, act, exp, cyc);
        end
    endfunction

    // Model: operation timeline measured in cycles since the accept handshake
    always @(negedge clk) begin
        int win, att, ph, s;
        bit e_r0, e_r1, e_v;
        logic [7:0] e_aa, e_ab;
        cyc++;
        if (m_on) begin
            if (m_busy) m_k++;
            win = -1; att = 0; ph = 0; e_r0 = 0; e_r1 = 0; e_v = 0; e_aa = 0; e_ab = 0;
            m_corrupt = 0;
            if (!m_busy) begin
                if (req0_valid && req1_valid) win = m_ptr ? 0 : 1;
                else if (req0_valid) win = 0;
                else if (req1_valid) win = 1;
                e_r0 = (win == 0);
                e_r1 = (win == 1);
            end else if (m_k < m_done) begin
                att = (m_k - 1) / 3;
                ph  = (m_k - 1) % 3;
                if (ph == 0) begin
                    e_aa = m_a; e_ab = m_b;
                end else if (ph == 1) begin
                    e_aa = m_b; e_ab = m_a;
                    m_corrupt = (att < m_c);
                end
            end else e_v = 1;
            chk("req0_ready", req0_ready, e_r0);
            chk("req1_ready", req1_ready, e_r1);
            chk("add_a", add_a, e_aa);
            chk("add_b", add_b, e_ab);
            chk("rsp_valid", rsp_valid, e_v);
            chk("mismatch_cnt", mismatch_cnt, m_mcnt);
            if (e_v) begin
                chk("rsp_sum", rsp_sum, m_sum);
                chk("rsp_id", rsp_id, m_id);
                chk("rsp_err", rsp_err, m_err);
            end
            if (m_busy && rsp_valid && !obs_seen) begin
                obs_seen = 1;
                obs_lat  = m_k;
            end
            if (rst) begin
                m_busy = 0; m_ptr = 1; m_mcnt = 0; m_corrupt = 0;
            end else if (win >= 0) begin
                m_busy = 1; m_k = 0; m_id = win[0]; m_ptr = win[0]; last_id = win[0];
                m_a = win[0] ? req1_a : req0_a;
                m_b = win[0] ? req1_b : req0_b;
                m_c = corr_c;
                m_err = m_c > MR;
                m_done = 3 * (m_err ? MR + 1 : m_c + 1) + 1;
                s = int'($signed(m_a)) + int'($signed(m_b));
                m_sum = s[8:0];
                obs_seen = 0;
                acc_t.push_back(cyc);
                acc_id.push_back(win[0]);
            end else if (m_busy && !e_v && ph == 2 && att < m_c) begin
                m_mcnt = (m_mcnt == 255) ? 255 : m_mcnt + 1;
            end else if (e_v && rsp_ready) begin
                m_busy = 0;
                obs_sum = rsp_sum; obs_id = rsp_id; obs_err = rsp_err; obs_mcnt = mismatch_cnt;
            end
        end else if (rst) begin
            m_on = 1; m_busy = 0; m_ptr = 1; m_mcnt = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input bit id, input logic [7:0] a, input logic [7:0] b);
        if (id) begin
            req1_a = a; req1_b = b; req1_valid = 1;
        end else begin
            req0_a = a; req0_b = b; req0_valid = 1;
        end
    endtask

    task automatic wait_acc(input int n, input bit drop);
        int t = 0;
        while (acc_t.size() < n && t < 200) begin
            tick();
            t++;
        end
        chk("accept_wait", acc_t.size() >= n, 1);
        if (drop) begin
            if (last_id) req1_valid = 0;
            else req0_valid = 0;
        end
    endtask

    task automatic wait_idle();
        int t = 0;
        while (m_busy && t < 200) begin
            tick();
            t++;
        end
        chk("idle_wait", m_busy, 0);
    endtask

    task automatic issue(input bit id, input logic [7:0] a, input logic [7:0] b, input int c);
        corr_c = c;
        req(id, a, b);
        wait_acc(acc_t.size() + 1, 1);
    endtask

    task automatic do_reset();
        req0_valid = 0; req1_valid = 0;
        rst = 1;
        tick();
        rst = 0;
    endtask

    function automatic int rc();
        return ($urandom_range(0, 3) == 0) ? $urandom_range(1, MR + 1) : 0;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, t;
        tick();
        tick();
        rst = 0;
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_rsp_sum", rsp_sum, 0);
        chk("reset_add_a", add_a, 0);
        chk("reset_mcnt", mismatch_cnt, 0);

        issue(0, 8'h7F, 8'h01, 0);
        wait_idle();
        chk("t1_latency", obs_lat, 4);
        chk("t1_sum", obs_sum, 'h080);
        chk("t1_id", obs_id, 0);
        chk("t1_err", obs_err, 0);
        chk("t1_mcnt", obs_mcnt, 0);

        issue(1, 8'h80, 8'h80, 0);
        wait_idle();
        chk("t2a_sum", obs_sum, 'h100);
        chk("t2a_id", obs_id, 1);
        issue(1, 8'hFF, 8'h01, 0);
        wait_idle();
        chk("t2b_sum", obs_sum, 'h000);

        do_reset();
        issue(1, 8'hC8, 8'h05, 1);
        wait_idle();
        chk("retry_latency", obs_lat, 7);
        chk("retry_sum", obs_sum, 'h1CD);
        chk("retry_err", obs_err, 0);
        chk("retry_mcnt", obs_mcnt, 1);

        do_reset();
        rdy_fixed = 0;
        issue(0, 8'h10, 8'h22, 3);
        t = 0;
        while (!rsp_valid && t < 50) begin
            tick();
            t++;
        end
        repeat (5) tick();
        rdy_fixed = 1;
        wait_idle();
        chk("persist_latency", obs_lat, 10);
        chk("persist_sum", obs_sum, 'h032);
        chk("persist_err", obs_err, 1);
        chk("persist_mcnt", obs_mcnt, 3);

        issue(0, 8'h33, 8'h44, 0);
        tick();
        rst = 1;
        tick();
        rst = 0;
        chk("midrst_rsp_valid", rsp_valid, 0);
        chk("midrst_add_a", add_a, 0);
        chk("midrst_add_b", add_b, 0);
        chk("midrst_mcnt", mismatch_cnt, 0);

        corr_c = 0;
        n = acc_t.size();
        req(0, 8'h11, 8'h22);
        req(1, 8'hF0, 8'h05);
        wait_acc(n + 4, 0);
        req0_valid = 0;
        req1_valid = 0;
        wait_idle();
        if (acc_t.size() >= n + 4) begin
            for (int i = 0; i < 4; i++) chk("tie_order", acc_id[n + i], i % 2);
            for (int i = 1; i < 4; i++) chk("tie_spacing", acc_t[n + i] - acc_t[n + i - 1], 5);
        end

        rand_mode = 1;
        for (int i = 0; i < 150; i++) begin
            n = acc_t.size();
            if ($urandom_range(0, 3) == 0) begin
                corr_c = rc();
                req(0, 8'($urandom), 8'($urandom));
                req(1, 8'($urandom), 8'($urandom));
                wait_acc(n + 1, 1);
                corr_c = rc();
                wait_idle();
                wait_acc(n + 2, 1);
                wait_idle();
            end else begin
                issue($urandom_range(0, 1) == 1, 8'($urandom), 8'($urandom), rc());
                wait_idle();
            end
        end
        rand_mode = 0;
        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
